// File: rtl/fetch_aligner.sv
// Instruction fetch front end: prefetches 32-bit words into a small FIFO and
// aligns halfword-granular RV32IC instructions for the compressed expander.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        compressed_o
);

    localparam int IW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_pc;
    logic [31:0]     r_addr;
    logic            r_pend_valid;
    logic [31:0]     r_pend_addr;
    logic [31:0]     r_fifo [FIFO_DEPTH];
    logic [IW-1:0]   r_head;
    logic [IW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_drop;

    logic [CW:0]     w_inflight;
    logic            w_req;
    logic            w_gnt;
    logic            w_push;
    logic            w_drop_resp;
    logic [31:0]     w_head_word;
    logic [31:0]     w_next_word;
    logic [31:0]     w_instr;
    logic            w_valid;
    logic            w_pop;
    logic [31:0]     w_pc_inc;
    logic            w_fire;
    logic            w_pop_fifo;
    logic [31:0]     w_target;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
        return (idx == IW'(FIFO_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign w_inflight  = {1'b0, r_count} + {1'b0, r_outst};
    assign w_gnt       = w_req & instr_gnt_i;
    assign w_drop_resp = instr_rvalid_i && (r_drop != '0);
    assign w_push      = instr_rvalid_i && (r_drop == '0);
    assign w_head_word = r_fifo[r_head];
    assign w_next_word = r_fifo[idx_inc(r_head)];
    assign w_fire      = w_valid & instr_ready_i;
    assign w_pop_fifo  = w_fire & w_pop;
    assign w_target    = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        case (r_state)
            S_BOOT: w_state_next = S_RUN;
            S_RUN:  w_req = (w_inflight < (CW+1)'(FIFO_DEPTH));
            default: w_state_next = S_BOOT;
        endcase
    end

    // A 32-bit instruction at an odd halfword needs the next word as well.
    always_comb begin
        w_valid  = 1'b0;
        w_instr  = w_head_word;
        w_pop    = 1'b0;
        w_pc_inc = 32'd4;
        if (!r_pc[1]) begin
            w_valid = (r_count != '0);
            if (w_head_word[1:0] != 2'b11) begin
                w_instr  = {16'b0, w_head_word[15:0]};
                w_pc_inc = 32'd2;
            end else begin
                w_pop = 1'b1;
            end
        end else begin
            w_pop = 1'b1;
            if (w_head_word[17:16] != 2'b11) begin
                w_instr  = {16'b0, w_head_word[31:16]};
                w_pc_inc = 32'd2;
                w_valid  = (r_count != '0);
            end else begin
                w_instr = {w_next_word[15:0], w_head_word[31:16]};
                w_valid = (r_count >= CW'(2));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_addr       <= {RESET_PC[31:2], 2'b00};
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_outst      <= '0;
            r_drop       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            r_state <= w_state_next;
            r_outst <= r_outst + CW'(w_gnt) - CW'(instr_rvalid_i);

            if (redirect_i) begin
                r_pc    <= redirect_pc_i & ~32'd1;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_drop  <= r_outst - CW'(instr_rvalid_i) + CW'(w_req);
            end else begin
                if (w_fire) r_pc <= r_pc + w_pc_inc;
                if (w_push) begin
                    r_fifo[r_tail] <= instr_rdata_i;
                    r_tail         <= idx_inc(r_tail);
                end
                if (w_pop_fifo) r_head <= idx_inc(r_head);
                r_count <= r_count + CW'(w_push) - CW'(w_pop_fifo);
                if (w_drop_resp) r_drop <= r_drop - 1'b1;
            end

            // An un-granted request keeps its address; the target is parked until gnt.
            if (w_gnt) begin
                r_pend_valid <= 1'b0;
                if (redirect_i)        r_addr <= w_target;
                else if (r_pend_valid) r_addr <= r_pend_addr;
                else                   r_addr <= r_addr + 32'd4;
            end else if (redirect_i) begin
                if (w_req) begin
                    r_pend_valid <= 1'b1;
                    r_pend_addr  <= w_target;
                end else begin
                    r_pend_valid <= 1'b0;
                    r_addr       <= w_target;
                end
            end
        end
    end

    assign instr_req_o   = w_req;
    assign instr_addr_o  = r_addr;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_instr;
    assign instr_pc_o    = r_pc;
    assign compressed_o  = (w_instr[1:0] != 2'b11);

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner with an in-order memory model
// whose grant enable and response latency are set per scenario.
module tb_fetch_aligner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        compressed_o;

    int          checks = 0;
    int          errors = 0;
    int          respLat = 1;
    bit          gntEn = 1'b1;
    logic [31:0] mem [256];
    logic        p1 = 1'b0;
    logic        p2 = 1'b0;
    logic [31:0] p1a = 32'h0;
    logic [31:0] p2a = 32'h0;

    fetch_aligner dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .compressed_o   (compressed_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: grants and responses change 2 time units after each rising edge.
    always @(posedge clk_i) begin
        #2;
        if (!rst_ni) begin
            p1 = 1'b0;
            p2 = 1'b0;
            instr_rvalid_i = 1'b0;
            instr_gnt_i = 1'b0;
        end else begin
            instr_rvalid_i = (respLat == 1) ? p1 : p2;
            instr_rdata_i = (respLat == 1) ? mem[p1a[9:2]] : mem[p2a[9:2]];
            p2 = p1;
            p2a = p1a;
            instr_gnt_i = gntEn && instr_req_o;
            p1 = instr_gnt_i;
            p1a = instr_addr_o;
        end
    end

    task automatic applyReset(input int lat, input bit ge);
        rst_ni = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        respLat = lat;
        gntEn = ge;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic waitValid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (instr_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_ni = 1'b0;
        instr_ready_i = 1'b1;
        gntEn = 1'b1;
        respLat = 1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        repeat (2) @(negedge clk_i);
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000000", instr_addr_o); end
        checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00000000", instr_pc_o); end
        rst_ni = 1'b1;
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL reset_run_valid: got timeout expected valid"); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid: got %b expected 0", instr_valid_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_addr: got %h expected 00000000", instr_addr_o); end
    endtask

    task automatic test_basic_fetch();
        bit ok;
        logic [31:0] expI [2] = '{32'h0050_0093, 32'h00A0_0113};
        logic [31:0] expP [2] = '{32'h0, 32'h4};
        applyReset(1, 1'b1);
        mem[0] = expI[0];
        mem[1] = expI[1];
        @(negedge clk_i);
        checks++; if (instr_req_o !== 1'b1) begin errors++; $display("[TB] FAIL boot_req: got %b expected 1", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL boot_addr: got %h expected 00000000", instr_addr_o); end
        for (int i = 0; i < 2; i++) begin
            waitValid(10, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout[%0d]: got timeout expected valid", i); end
            checks++; if (instr_o !== expI[i]) begin errors++; $display("[TB] FAIL basic_instr[%0d]: got %h expected %h", i, instr_o, expI[i]); end
            checks++; if (instr_pc_o !== expP[i]) begin errors++; $display("[TB] FAIL basic_pc[%0d]: got %h expected %h", i, instr_pc_o, expP[i]); end
            checks++; if (compressed_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_c[%0d]: got %b expected 0", i, compressed_o); end
        end
    endtask

    task automatic test_compressed_pair();
        bit ok;
        logic [31:0] expI [3] = '{32'h0000_4581, 32'h0000_4051, 32'h0000_0013};
        logic [31:0] expP [3] = '{32'h0, 32'h2, 32'h4};
        logic        expC [3] = '{1'b1, 1'b1, 1'b0};
        applyReset(1, 1'b1);
        mem[0] = 32'h4051_4581;
        for (int i = 0; i < 3; i++) begin
            waitValid(10, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL cpair_timeout[%0d]: got timeout expected valid", i); end
            checks++; if (instr_o !== expI[i]) begin errors++; $display("[TB] FAIL cpair_instr[%0d]: got %h expected %h", i, instr_o, expI[i]); end
            checks++; if (instr_pc_o !== expP[i]) begin errors++; $display("[TB] FAIL cpair_pc[%0d]: got %h expected %h", i, instr_pc_o, expP[i]); end
            checks++; if (compressed_o !== expC[i]) begin errors++; $display("[TB] FAIL cpair_c[%0d]: got %b expected %b", i, compressed_o, expC[i]); end
        end
    endtask

    task automatic test_straddle();
        bit ok;
        logic [31:0] expI [3] = '{32'h0000_0001, 32'h0050_0093, 32'h0000_1234};
        logic [31:0] expP [3] = '{32'h0, 32'h2, 32'h6};
        logic        expC [3] = '{1'b1, 1'b0, 1'b1};
        applyReset(1, 1'b1);
        mem[0] = 32'h0093_0001;
        mem[1] = 32'h1234_0050;
        @(negedge clk_i);
        gntEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waitValid(12, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL strad_timeout[%0d]: got timeout expected valid", i); end
            checks++; if (instr_o !== expI[i]) begin errors++; $display("[TB] FAIL strad_instr[%0d]: got %h expected %h", i, instr_o, expI[i]); end
            checks++; if (instr_pc_o !== expP[i]) begin errors++; $display("[TB] FAIL strad_pc[%0d]: got %h expected %h", i, instr_pc_o, expP[i]); end
            checks++; if (compressed_o !== expC[i]) begin errors++; $display("[TB] FAIL strad_c[%0d]: got %b expected %b", i, compressed_o, expC[i]); end
            if (i == 0) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_i);
                    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL strad_hold_valid[%0d]: got %b expected 0", k, instr_valid_o); end
                    checks++; if (instr_addr_o !== 32'h4) begin errors++; $display("[TB] FAIL strad_hold_addr[%0d]: got %h expected 00000004", k, instr_addr_o); end
                end
                gntEn = 1'b1;
            end
        end
    endtask

    task automatic test_redirect_drop();
        bit ok;
        logic [31:0] expI [2] = '{32'h0000_4581, 32'h0000_0013};
        logic [31:0] expP [2] = '{32'h106, 32'h108};
        logic        expC [2] = '{1'b1, 1'b0};
        applyReset(2, 1'b1);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[8'h41] = 32'h4581_0013;
        repeat (2) @(negedge clk_i);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0107;
        @(negedge clk_i);
        redirect_i = 1'b0;
        checks++; if (instr_pc_o !== 32'h106) begin errors++; $display("[TB] FAIL redir_pc: got %h expected 00000106", instr_pc_o); end
        checks++; if (instr_addr_o !== 32'h104) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 00000104", instr_addr_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL redir_req: got %b expected 0", instr_req_o); end
        for (int i = 0; i < 2; i++) begin
            waitValid(20, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL redir_timeout[%0d]: got timeout expected valid", i); end
            checks++; if (instr_o !== expI[i]) begin errors++; $display("[TB] FAIL redir_instr[%0d]: got %h expected %h", i, instr_o, expI[i]); end
            checks++; if (instr_pc_o !== expP[i]) begin errors++; $display("[TB] FAIL redir_ipc[%0d]: got %h expected %h", i, instr_pc_o, expP[i]); end
            checks++; if (compressed_o !== expC[i]) begin errors++; $display("[TB] FAIL redir_c[%0d]: got %b expected %b", i, compressed_o, expC[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        applyReset(1, 1'b1);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        instr_ready_i = 1'b0;
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_timeout: got timeout expected valid"); end
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk_i);
            checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid_o); end
            checks++; if (instr_o !== 32'h0050_0093) begin errors++; $display("[TB] FAIL stall_instr[%0d]: got %h expected 00500093", i, instr_o); end
            checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h expected 00000000", i, instr_pc_o); end
            checks++; if (instr_req_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_req[%0d]: got %b expected 0", i, instr_req_o); end
        end
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (instr_req_o !== 1'b1) begin errors++; $display("[TB] FAIL resume_req: got %b expected 1", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h8) begin errors++; $display("[TB] FAIL resume_addr: got %h expected 00000008", instr_addr_o); end
        checks++; if (instr_o !== 32'h00A0_0113) begin errors++; $display("[TB] FAIL resume_instr: got %h expected 00a00113", instr_o); end
        checks++; if (instr_pc_o !== 32'h4) begin errors++; $display("[TB] FAIL resume_pc: got %h expected 00000004", instr_pc_o); end
    endtask

    task automatic test_gnt_stall_redirect();
        bit ok;
        applyReset(1, 1'b0);
        mem[0] = 32'h0050_0093;
        mem[8'h80] = 32'h00C0_0193;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++; if (instr_req_o !== 1'b1) begin errors++; $display("[TB] FAIL gstall_req[%0d]: got %b expected 1", i, instr_req_o); end
            checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL gstall_addr[%0d]: got %h expected 00000000", i, instr_addr_o); end
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        @(negedge clk_i);
        redirect_i = 1'b0;
        checks++; if (instr_req_o !== 1'b1) begin errors++; $display("[TB] FAIL gstall_held_req: got %b expected 1", instr_req_o); end
        checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL gstall_held_addr: got %h expected 00000000", instr_addr_o); end
        gntEn = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (instr_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL gstall_target_addr: got %h expected 00000200", instr_addr_o); end
        waitValid(12, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL gstall_timeout: got timeout expected valid"); end
        checks++; if (instr_o !== 32'h00C0_0193) begin errors++; $display("[TB] FAIL gstall_instr: got %h expected 00c00193", instr_o); end
        checks++; if (instr_pc_o !== 32'h200) begin errors++; $display("[TB] FAIL gstall_pc: got %h expected 00000200", instr_pc_o); end
    endtask

    // Scenarios run back to back; each one starts from its own reset.
    initial begin
        $display("[TB] starting fetch_aligner bench");
        test_reset();
        test_basic_fetch();
        test_compressed_pair();
        test_straddle();
        test_redirect_drop();
        test_backpressure();
        test_gnt_stall_redirect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction fetch front end of the core. It prefetches 32-bit words from instruction memory into a small word FIFO.
- It aligns halfword-granular RISC-V instructions (RV32I plus C extension) and presents one raw instruction per handshake.
- Consumer is the compressed expander, which feeds the decoder.
- Branch/jump redirects flush the FIFO and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (halfword aligned)
FIFO_DEPTH, 2, word FIFO entries; also the maximum number of outstanding plus buffered words

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
instr_req_o  out  1  memory request
instr_addr_o  out  32  word-aligned fetch address, bits[1:0]=0
instr_gnt_i  in  1  request accepted this cycle
instr_rvalid_i  in  1  read data valid; responses return in order, at least 1 cycle after gnt
instr_rdata_i  in  32  read data
redirect_i  in  1  branch/jump taken, flush and refetch
redirect_pc_i  in  32  new PC; bit0 ignored
instr_valid_o  out  1  instr_o/instr_pc_o/compressed_o valid
instr_ready_i  in  1  downstream accepts the instruction
instr_o  out  32  raw instruction; compressed form occupies [15:0], [31:16]=0
instr_pc_o  out  32  PC of instr_o
compressed_o  out  1  instr_o[1:0] != 2'b11

Behaviour:
- Reset (async assert), values of every output and state:
  - instr_valid_o=0, instr_req_o=0, instr_addr_o={RESET_PC[31:2],2'b00}, instr_pc_o=RESET_PC.
  - FIFO empty; outstanding=0; drop=0.
  - Reset mid-transaction discards everything, including later rvalid from pre-reset requests; the bench must not send them.
- State machine:
  - S_BOOT (one cycle after reset release, no request) -> S_RUN.
  - S_RUN -> S_RUN on redirect (flush actions below).
- Request rule: instr_req_o=1 in S_RUN when fifo_count + outstanding < FIFO_DEPTH.
  - While req=1 and gnt=0, instr_addr_o and req are held stable, even across a redirect.
  - On gnt: outstanding+1 and instr_addr_o += 4.
- Response: rvalid with drop>0 discards the data and decrements drop. Otherwise the word is pushed with its address and outstanding-1. Push and pop in the same cycle are allowed.
- Alignment uses pc (instr_pc_o) and head word H (address = pc[31:2]<<2).
  - pc[1]=0, H[1:0]!=11: compressed, instr_o={16'b0,H[15:0]}. Valid when head exists. Fire leaves H in place with pc+=2.
  - pc[1]=0, 32-bit: instr_o=H. Fire pops H, pc+=4.
  - pc[1]=1, H[17:16]!=11: compressed, instr_o={16'b0,H[31:16]}. Fire pops H, pc+=2.
  - pc[1]=1, 32-bit: needs H and the next entry N; instr_o={N[15:0],H[31:16]}. Valid only with 2 entries. Fire pops H, pc+=4 (N becomes head, low half consumed).
  - FIFO_DEPTH must be >=2 so a straddling instruction can complete.
- Output timing:
  - instr_o, instr_valid_o and compressed_o are combinational from FIFO state and pc; no rvalid->valid combinational path.
  - Fire = instr_valid_o & instr_ready_i.
  - Outputs are stable while valid=1 and ready=0, absent a redirect.
- Redirect (registered effect, next cycle):
  - pc<=redirect_pc_i & ~1; FIFO cleared; instr_valid_o=0.
  - drop<=outstanding minus any rvalid this cycle, plus 1 if a request is pending un-granted (it completes and is dropped).
  - The next request address is {redirect_pc_i[31:2],2'b00}.
  - A target with bit1=1 uses the upper half of the first word.
- Redirect with fire in the same cycle: the handshake completes (downstream took the instruction), and the redirect wins for all state.
- Minimum redirect latency with immediate gnt and 1-cycle rvalid: redirect at cycle 0, req at c1, rvalid at c2, instr_valid_o at c3.
- pc wraps modulo 2^32; the address increment wraps as well.

Test Plan:
- Reset, RESET_PC=0, memory returns 32'h00500093 at 0 and 32'h00A00113 at 4 with gnt=1, rvalid 1 cycle later, ready=1 -> instr_o 00500093 @pc0, then 00A00113 @pc4, compressed_o=0; first req in cycle after S_BOOT.
- Word 0 = 32'h40514581 (two compressed) -> instr_o 00004581 @0, then 00004051 @2, compressed_o=1; one memory word used.
- Word 0 = 32'h00930001, word 4 = 32'h????0050 -> 0001 @0 compressed, then straddling 32'h00500093 @2 (held invalid until word 4 arrives).
- redirect_pc_i=32'h0000_0106 with two responses outstanding -> both rvalid data dropped; next req addr 0x104; first instr taken from upper half @0x106.
- ready=0 for 5 cycles with valid=1 -> instr_o/instr_pc_o constant; req stops once fifo_count+outstanding=2; resumes one cycle after fire.
- gnt held 0 for 3 cycles, then redirect -> addr unchanged until gnt, that response dropped, then req at target word.
